// File: rtl/mem_loader_if.sv
// Byte-stream / memory-write bundle shared between the memory loader and its
// environment. The master side supplies the control request and the byte stream;
// the slave side, which is the loader, drives the memory write port and status.
interface mem_loader_if #(
    parameter int ADDRWIDTH = 8
);
    logic                 start;
    logic [ADDRWIDTH:0]   wordcount;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 byte_ready;
    logic                 mem_we;
    logic [ADDRWIDTH-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic                 core_nreset;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        output start, wordcount, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, core_nreset, busy, done, error
    );

    modport slave (
        input  start, wordcount, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, core_nreset, busy, done, error
    );
endinterface

// File: rtl/mem_loader.sv
// Memory loader: gathers a little-endian byte stream into 32-bit words and writes
// them to consecutive word addresses starting at 0. It holds the riscv32s core in
// reset from power-up until a load completes. Every output is a register that is
// loaded with the value belonging to the state being entered.
module mem_loader #(
    parameter int ADDRWIDTH = 8,
    parameter int MEMDEPTH  = 256
) (
    input  logic          clock,
    input  logic          nreset,
    mem_loader_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [ADDRWIDTH:0] DEPTH_C = (ADDRWIDTH+1)'(MEMDEPTH);
    localparam logic [ADDRWIDTH:0] ONE_C   = (ADDRWIDTH+1)'(1);
    localparam logic [ADDRWIDTH:0] ZERO_C  = {(ADDRWIDTH+1){1'b0}};

    state_t               state_r;
    logic [ADDRWIDTH:0]   count_r;
    logic [ADDRWIDTH:0]   word_cnt_r;
    logic [1:0]           byte_cnt_r;
    logic [31:0]          asm_r;

    logic                 byte_ready_r;
    logic                 mem_we_r;
    logic [ADDRWIDTH-1:0] mem_addr_r;
    logic [31:0]          mem_wdata_r;
    logic                 core_nreset_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 error_r;

    logic                 start_ok_s;
    logic [ADDRWIDTH:0]   next_word_s;
    logic                 byte_acc_s;
    logic [31:0]          asm_next_s;

    // Places byte b into lane idx of word; lane 0 is the least-significant byte.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] res;
        res = word;
        case (idx)
            2'd0:    res[7:0]   = b;
            2'd1:    res[15:8]  = b;
            2'd2:    res[23:16] = b;
            2'd3:    res[31:24] = b;
            default: res        = word;
        endcase
        return res;
    endfunction

    assign start_ok_s  = (bus.wordcount != ZERO_C) && (bus.wordcount <= DEPTH_C);
    assign next_word_s = word_cnt_r + ONE_C;
    assign byte_acc_s  = bus.byte_valid && byte_ready_r;
    assign asm_next_s  = insert_byte(asm_r, byte_cnt_r, bus.byte_data);

    // Load sequencer: state, counters, assembly register and all registered outputs.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r       <= IDLE;
            count_r       <= ZERO_C;
            word_cnt_r    <= ZERO_C;
            byte_cnt_r    <= 2'd0;
            asm_r         <= 32'd0;
            byte_ready_r  <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= {ADDRWIDTH{1'b0}};
            mem_wdata_r   <= 32'd0;
            core_nreset_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            // Strobes default low so each one lasts exactly one cycle.
            mem_we_r <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        if (start_ok_s) begin
                            count_r       <= bus.wordcount;
                            word_cnt_r    <= ZERO_C;
                            byte_cnt_r    <= 2'd0;
                            asm_r         <= 32'd0;
                            core_nreset_r <= 1'b0;
                            byte_ready_r  <= 1'b1;
                            busy_r        <= 1'b1;
                            state_r       <= RECV;
                        end else begin
                            // Rejected request: core_nreset is deliberately untouched.
                            error_r <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    // A stalled stream simply leaves everything as it is.
                    if (byte_acc_s) begin
                        asm_r      <= asm_next_s;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            byte_ready_r <= 1'b0;
                            mem_we_r     <= 1'b1;
                            mem_addr_r   <= word_cnt_r[ADDRWIDTH-1:0];
                            mem_wdata_r  <= asm_next_s;
                            state_r      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    word_cnt_r <= next_word_s;
                    if (next_word_s == count_r) begin
                        done_r        <= 1'b1;
                        core_nreset_r <= 1'b1;
                        state_r       <= FINISH;
                    end else begin
                        byte_ready_r <= 1'b1;
                        state_r      <= RECV;
                    end
                end
                FINISH: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    byte_ready_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.byte_ready  = byte_ready_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.core_nreset = core_nreset_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.error       = error_r;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a bench-side memory captures every write, and the
// contents, write counts, pulse counts and load timing are compared with values
// worked out by hand from the byte streams.
module tb_mem_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic clock = 1'b0;
    logic nreset;

    mem_loader_if #(.ADDRWIDTH(AW)) bus ();

    mem_loader #(.ADDRWIDTH(AW), .MEMDEPTH(DEPTH)) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mem  [DEPTH];
    int          hits [DEPTH];
    logic [7:0]  stream [4*DEPTH];
    int          cyc = 0;
    int          wr_cnt, done_cnt, err_cnt, done_edge, last_addr, rdy_in_write, t0;
    logic        core_prev, core_at_done, core_before_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = 32'd0;
            hits[i] = 0;
        end
        wr_cnt = 0; done_cnt = 0; err_cnt = 0; rdy_in_write = 0;
        done_edge = -1; last_addr = -1;
    endtask

    // One clock: acc reports whether a byte was taken at this edge; outputs are
    // sampled 1 time unit after the edge. done_edge is the edge at which a
    // synchronous consumer would capture done.
    task automatic tick(output logic acc);
        acc = (bus.byte_valid === 1'b1) && (bus.byte_ready === 1'b1);
        @(posedge clock);
        #1;
        cyc++;
        if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            hits[bus.mem_addr]++;
            wr_cnt++;
            last_addr = int'(bus.mem_addr);
            if (bus.byte_ready === 1'b1) rdy_in_write++;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_edge        = cyc + 1;
            core_at_done     = bus.core_nreset;
            core_before_done = core_prev;
        end
        if (bus.error === 1'b1) err_cnt++;
        core_prev = bus.core_nreset;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic start_load(input int wc);
        logic a;
        bus.start     = 1'b1;
        bus.wordcount = (AW+1)'(wc);
        tick(a);
        t0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int   n;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        check("byte_accept", acc, 1);
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            idle(gap);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_hits, mism;
        logic [31:0] w;

        nreset = 1'b0;
        bus.start = 1'b0; bus.wordcount = '0; bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
        core_prev = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.byte_ready, 0);
        check("rst_core", bus.core_nreset, 0);
        check("rst_we_done_err", {bus.mem_we, bus.done, bus.error}, 0);
        check("rst_addr_data", {bus.mem_addr, bus.mem_wdata}, 0);
        idle(2);
        @(negedge clock);
        nreset = 1'b1;
        idle(2);

        // Rejected starts.
        clear_model();
        start_load(0);
        check("err0_pulse", bus.error, 1);
        check("err0_busy", bus.busy, 0);
        idle(1);
        check("err0_one_cycle", bus.error, 0);
        start_load(DEPTH + 1);
        check("err257_pulse", bus.error, 1);
        idle(3);
        check("err_count", err_cnt, 2);
        check("err_no_we", wr_cnt, 0);
        check("err_core_held", bus.core_nreset, 0);
        check("err_busy", bus.busy, 0);

        // Two words back-to-back.
        clear_model();
        start_load(2);
        check("w2_busy", bus.busy, 1);
        check("w2_ready", bus.byte_ready, 1);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 4);
        check("w2_writes", wr_cnt, 2);
        check("w2_mem0", mem[0], 32'h00000013);
        check("w2_mem1", mem[1], 32'h00100093);
        check("w2_done_cnt", done_cnt, 1);
        check("w2_cycles", done_edge - t0, 11);
        check("w2_core_at_done", core_at_done, 1);
        check("w2_core_before", core_before_done, 0);
        check("w2_idle_busy", bus.busy, 0);

        // One word with byte_valid toggling.
        clear_model();
        start_load(1);
        check("w1t_core_rehold", bus.core_nreset, 0);
        send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1); send_byte(8'hDE, 4);
        check("w1t_writes", wr_cnt, 1);
        check("w1t_mem0", mem[0], 32'hDEADBEEF);
        check("w1t_addr", last_addr, 0);
        check("w1t_ready_in_write", rdy_in_write, 0);
        check("w1t_done", done_cnt, 1);

        // Three words with a second start mid-load.
        clear_model();
        start_load(3);
        send_byte(8'h44, 0); send_byte(8'h33, 0); send_byte(8'h22, 0); send_byte(8'h11, 0);
        send_byte(8'h88, 0); send_byte(8'h77, 0);
        bus.start = 1'b1; bus.wordcount = 9'd1;
        send_byte(8'h66, 0);
        bus.start = 1'b0;
        send_byte(8'h55, 0);
        send_byte(8'hCC, 0); send_byte(8'hBB, 0); send_byte(8'hAA, 0); send_byte(8'h99, 4);
        check("w3_writes", wr_cnt, 3);
        check("w3_mem0", mem[0], 32'h11223344);
        check("w3_mem1", mem[1], 32'h55667788);
        check("w3_mem2", mem[2], 32'h99AABBCC);
        check("w3_hits", {hits[0][7:0], hits[1][7:0], hits[2][7:0]}, 24'h010101);
        check("w3_last_addr", last_addr, 2);
        check("w3_done", done_cnt, 1);
        check("w3_cycles", done_edge - t0, 16);
        check("w3_no_err", err_cnt, 0);

        // Reset after six bytes of a two-word load.
        clear_model();
        start_load(2);
        send_byte(8'hD4, 0); send_byte(8'hC3, 0); send_byte(8'hB2, 0); send_byte(8'hA1, 0);
        send_byte(8'hE5, 0); send_byte(8'hF6, 0);
        nreset = 1'b0;
        #1;
        check("rl_busy", bus.busy, 0);
        check("rl_ready", bus.byte_ready, 0);
        check("rl_core", bus.core_nreset, 0);
        check("rl_we_addr_data", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        idle(3);
        @(negedge clock);
        nreset = 1'b1;
        bus.byte_valid = 1'b0;
        idle(3);
        check("rl_writes", wr_cnt, 1);
        check("rl_first_word", mem[0], 32'hA1B2C3D4);
        check("rl_core_held", bus.core_nreset, 0);
        clear_model();
        start_load(1);
        send_byte(8'hA9, 0); send_byte(8'hCB, 0); send_byte(8'hED, 0); send_byte(8'h0F, 4);
        check("rl_new_writes", wr_cnt, 1);
        check("rl_new_mem0", mem[0], 32'h0FEDCBA9);
        check("rl_new_addr", last_addr, 0);
        check("rl_new_core", bus.core_nreset, 1);

        // Full-depth load with random data.
        clear_model();
        for (int i = 0; i < 4*DEPTH; i++) stream[i] = 8'($urandom);
        start_load(DEPTH);
        for (int i = 0; i < 4*DEPTH; i++) send_byte(stream[i], (i == 4*DEPTH-1) ? 4 : 0);
        bad_hits = 0;
        mism     = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w = {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
            if (hits[i] != 1) bad_hits++;
            if (mem[i] !== w) mism++;
        end
        check("full_writes", wr_cnt, DEPTH);
        check("full_bad_hits", bad_hits, 0);
        check("full_last_addr", last_addr, DEPTH - 1);
        check("full_data_mism", mism, 0);
        check("full_done", done_cnt, 1);
        check("full_cycles", done_edge - t0, 5*DEPTH + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 8, meaning the word-address width of the target memory.
REQ-002 SHALL have parameter MEMDEPTH, default 256, meaning the number of 32-bit words in the target memory.
REQ-003 SHALL have port clock  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port nreset  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning a one-cycle request to begin a load.
REQ-006 SHALL have port wordcount  input  ADDRWIDTH+1  meaning the number of words to load, sampled when start is accepted.
REQ-007 SHALL have port byte_valid  input  1  meaning byte_data holds a valid byte.
REQ-008 SHALL have port byte_data  input  8  meaning the incoming byte stream, least-significant byte of each word first.
REQ-009 SHALL have port byte_ready  output  1  meaning the loader can accept a byte this cycle.
REQ-010 SHALL have port mem_we  output  1  meaning the word write strobe to memory.
REQ-011 SHALL have port mem_addr  output  ADDRWIDTH  meaning the word address being written.
REQ-012 SHALL have port mem_wdata  output  32  meaning the word being written.
REQ-013 SHALL have port core_nreset  output  1  meaning the active-low hold-in-reset signal for the riscv32s core.
REQ-014 SHALL have port busy  output  1  meaning a load is in progress.
REQ-015 SHALL have port done  output  1  meaning a one-cycle pulse when a load completes.
REQ-016 SHALL have port error  output  1  meaning a one-cycle pulse when start is rejected.

Function
REQ-017 SHALL implement the FSM states IDLE, RECV, WRITE and FINISH.
REQ-018 SHALL accept a byte only in a cycle where byte_valid=1 and byte_ready=1 at the rising edge.
REQ-019 SHALL drive byte_ready=1 only in RECV.
REQ-020 SHALL, in IDLE with start=1 and 1<=wordcount<=MEMDEPTH, latch wordcount, clear the word and byte counters, set core_nreset=0, and enter RECV.
REQ-021 SHALL, in IDLE with start=1 and wordcount=0 or wordcount>MEMDEPTH, pulse error for one cycle, stay in IDLE and leave core_nreset unchanged.
REQ-022 SHALL ignore start in RECV, WRITE and FINISH, and this SHALL NOT alter the latched count.
REQ-023 SHALL, in RECV, place accepted byte k (k=0..3) into bits [8k+7:8k] of the assembly register and increment a 2-bit byte counter.
REQ-024 SHALL, on accepting the 4th byte of a word, enter WRITE.
REQ-025 SHALL assert mem_we for exactly one cycle in WRITE, with mem_addr equal to the word counter and mem_wdata equal to the assembled word, so that mem_we is high in the cycle after the 4th byte is accepted.
REQ-026 SHALL drive mem_we=0 in every state except WRITE.
REQ-027 SHALL, on leaving WRITE, increment the word counter and then go to FINISH if the new count equals the latched count, otherwise return to RECV.
REQ-028 SHALL, in FINISH, pulse done for one cycle, set core_nreset=1, and return to IDLE.
REQ-029 SHALL drive busy=1 in RECV, WRITE and FINISH, and busy=0 in IDLE.
REQ-030 SHALL, when wordcount=MEMDEPTH, write addresses 0..MEMDEPTH-1 with no wrap and no write beyond MEMDEPTH-1.
REQ-031 SHALL hold state while byte_valid=0, with no timeout, and stalls of any length SHALL NOT corrupt the assembly register.
REQ-032 SHALL achieve a minimum load time of 5*N+1 cycles from the accepting start edge to done, for N words with byte_valid held at 1.

Reset
REQ-033 SHALL, on nreset=0 and asynchronously, enter IDLE, clear all counters and the assembly register, and drive core_nreset=0, mem_we=0, byte_ready=0, busy=0, done=0, error=0, mem_addr=0 and mem_wdata=0.
REQ-034 SHALL, on reset during a load, abandon the partial word with no further memory writes and keep the core held (core_nreset=0) until a later load completes.
REQ-035 SHALL keep core_nreset=0 after reset until the first successful done, so the core never runs from unloaded memory.

Verification
REQ-036 SHALL cover: wordcount=2 with bytes 13,00,00,00,93,00,10,00 streamed back-to-back -> mem[0]=0x00000013 and mem[1]=0x00100093, two mem_we pulses, done one cycle later, core_nreset rising with done, 11 cycles total.
REQ-037 SHALL cover: wordcount=1 with byte_valid toggling 1/0 every cycle and bytes EF,BE,AD,DE -> a single write of 0xDEADBEEF to address 0, with byte_ready=0 during WRITE.
REQ-038 SHALL cover: start with wordcount=0 and then with wordcount=MEMDEPTH+1 -> an error pulse each time, busy stays 0, core_nreset stays 0, and no mem_we.
REQ-039 SHALL cover: a second start while busy during a 3-word load -> ignored, exactly 3 writes to addresses 0,1,2, and one done.
REQ-040 SHALL cover: nreset asserted after 6 bytes of a 2-word load -> immediate IDLE, no further mem_we, and a fresh 1-word load then writes address 0 correctly.
REQ-041 SHALL cover: wordcount=MEMDEPTH with random data -> every address written once, the last write at MEMDEPTH-1, and the memory dump matching the stream.
